// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : arb_requester
// Description : Client front-end for one port of a two-requester arbiter.
//               Buffers producer words in a small circular FIFO, requests
//               the shared bus while data is held, drains one word per
//               granted cycle and yields after MAX_BURST words so the other
//               requester gets a turn.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_requester #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     req,
    input  logic                     gnt,
    output logic [DATA_W-1:0]        bus_data,
    output logic                     bus_valid
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [c_CNT_W-1:0]   c_CNT_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ZERO  = '0;
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_BURST_W-1:0] c_BURST_ONE = c_BURST_W'(1);
    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(MAX_BURST);

    // Two-bit state encoding; req is carried in its own register so it
    // never glitches while the state bits change.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_XFER  = 2'd2,
        S_YIELD = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Storage and control registers
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    state_t               r_state;
    logic [c_BURST_W-1:0] r_burst;
    logic                 r_req;
    logic [DATA_W-1:0]    r_bus_data;
    logic                 r_bus_valid;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_acc;
    logic                 w_pop;
    logic                 w_pop_empties;
    logic [c_BURST_W-1:0] w_burst_inc;
    logic                 w_burst_done;

    // Status flags come straight from the registered occupancy.
    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == c_CNT_ZERO);

    // A write is judged against the pre-edge full flag, so a write while
    // full is dropped even if a pop frees a slot at the same edge.
    assign w_wr_acc = wr_en & ~w_full;

    // Only a live request can consume a grant; an empty FIFO never pops.
    assign w_pop = r_req & gnt & ~w_empty;

    // The pop about to happen drains the last word with nothing refilling it.
    assign w_pop_empties = (r_count == c_CNT_ONE) & ~w_wr_acc;

    assign w_burst_inc  = r_burst + c_BURST_ONE;
    assign w_burst_done = (w_burst_inc == c_BURST_MAX);

    // ------------------------------------------------------------------------
    // FIFO storage: payload only, pointers carry the validity
    // ------------------------------------------------------------------------
    // Write accepted words into the slot at the write pointer.
    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Bus output register: one cycle from sampled grant to bus_valid
    // ------------------------------------------------------------------------
    // Present the popped head word for one cycle; data holds between pops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bus_data  <= '0;
            r_bus_valid <= 1'b0;
        end else begin
            r_bus_valid <= w_pop;
            if (w_pop) begin
                r_bus_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Request / burst state machine
    // ------------------------------------------------------------------------
    // Sequence request, transfer and the one-cycle fairness yield.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_burst <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (w_pop) begin
                        r_burst <= c_BURST_ONE;
                        if (MAX_BURST == 1) begin
                            r_state <= S_YIELD;
                            r_req   <= 1'b0;
                        end else if (w_pop_empties) begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= S_XFER;
                            r_req   <= 1'b1;
                        end
                    end
                end

                S_XFER: begin
                    if (!gnt) begin
                        // Grant revoked: keep requesting, restart the burst.
                        r_burst <= '0;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end else if (w_pop) begin
                        r_burst <= w_burst_inc;
                        // Burst limit wins over running empty.
                        if (w_burst_done) begin
                            r_state <= S_YIELD;
                            r_req   <= 1'b0;
                        end else if (w_pop_empties) begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end

                S_YIELD: begin
                    r_burst <= '0;
                    if (!w_empty) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_burst <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign req       = r_req;
    assign bus_data  = r_bus_data;
    assign bus_valid = r_bus_valid;

endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_requester
// Description : Directed self-checking bench for arb_requester. Accepted
//               writes are queued as expected bus words; every bus_valid
//               pops and compares the head, and occupancy flags are checked
//               against the queue depth each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_requester;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int MAX_BURST = 4;

    logic              clock;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [2:0]        count;
    logic              req;
    logic              gnt;
    logic [DATA_W-1:0] bus_data;
    logic              bus_valid;

    int total = 0;
    int bad   = 0;
    int rx    = 0;
    logic [DATA_W-1:0] q[$];

    arb_requester #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .req       (req),
        .gnt       (gnt),
        .bus_data  (bus_data),
        .bus_valid (bus_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict acceptance from the model occupancy, then score
    // the bus and occupancy just after the edge.
    task automatic tick();
        bit                acc;
        logic [DATA_W-1:0] d;
        acc = (wr_en === 1'b1) && (q.size() < DEPTH);
        d   = wr_data;
        @(posedge clock);
        #1;
        if (bus_valid === 1'b1) begin
            rx++;
            if (q.size() == 0) chk("bus_spurious", bus_valid, 0);
            else               chk("bus_data", bus_data, q.pop_front());
        end
        if (acc) q.push_back(d);
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full",  full,  q.size() == DEPTH);
    endtask

    initial begin
        bit [8:0] t3_req;
        bit [8:0] t3_bv;
        bit [5:0] t4_req;
        bit [5:0] t4_bv;
        logic     d1;
        int       rx0;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        gnt     = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req",      req,       0);
        chk("rst_bus_valid",bus_valid, 0);
        chk("rst_bus_data", bus_data,  0);
        chk("rst_count",    count,     0);
        chk("rst_empty",    empty,     1);
        chk("rst_full",     full,      0);
        reset = 1'b0;
        tick();

        // ---------------- single word, arbiter-like delayed grant ----------------
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();                               // E0: write accepted
        wr_en = 1'b0;
        chk("t2_req_e0", req, 0);
        d1 = req; gnt = 1'b0;
        tick();                               // E1: IDLE -> REQ
        chk("t2_req_e1", req, 1);
        gnt = d1; d1 = req;
        tick();                               // E2: gnt still low at edge
        chk("t2_bv_e2", bus_valid, 0);
        chk("t2_req_e2", req, 1);
        gnt = d1; d1 = req;
        tick();                               // E3: pop sampled
        chk("t2_bv_e3",   bus_valid, 1);
        chk("t2_data_e3", bus_data,  8'h5A);
        chk("t2_req_e3",  req,       0);
        gnt = d1; d1 = req;
        tick();                               // E4: grant without req ignored
        chk("t2_bv_e4",  bus_valid, 0);
        chk("t2_req_e4", req,       0);
        gnt = 1'b0;

        // ---------------- burst of 4 then yield ----------------
        t3_req = 9'b011011110;
        t3_bv  = 9'b110111100;
        gnt = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_en   = (i < 6);
            wr_data = DATA_W'(i + 1);
            tick();
            chk($sformatf("t3_req_%0d", i), req,       t3_req[i]);
            chk($sformatf("t3_bv_%0d", i),  bus_valid, t3_bv[i]);
        end
        wr_en = 1'b0;
        gnt   = 1'b0;
        tick();
        chk("t3_req_idle", req, 0);

        // ---------------- full and overflow ----------------
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("t4_count_full", count, 4);
        chk("t4_full",       full,  1);
        t4_req = 6'b000111;
        t4_bv  = 6'b001111;
        gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t4_req_%0d", i), req,       t4_req[i]);
            chk($sformatf("t4_bv_%0d", i),  bus_valid, t4_bv[i]);
        end
        gnt = 1'b0;

        // ---------------- grant revocation ----------------
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(8'h20 + i);
            tick();
        end
        wr_en = 1'b0;
        gnt   = 1'b1;
        tick();
        tick();
        gnt = 1'b0;
        tick();
        chk("t5_req_revoked", req,       1);
        chk("t5_bv_revoked",  bus_valid, 0);
        tick();
        chk("t5_req_wait", req,       1);
        chk("t5_bv_wait",  bus_valid, 0);
        gnt = 1'b1;
        wr_en = 1'b1; wr_data = 8'h24;
        tick();
        chk("t5_bv_regrant", bus_valid, 1);
        wr_data = 8'h25;
        tick();
        chk("t5_req_fresh2", req, 1);
        wr_en = 1'b0;
        tick();
        chk("t5_req_fresh3", req, 1);
        tick();
        chk("t5_req_yield", req, 0);
        tick();
        chk("t5_req_idle", req, 0);
        gnt = 1'b0;

        // ---------------- wrap with concurrent write and pop ----------------
        rx0 = rx;
        gnt = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(8'h40 + i);
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            tick();
        end
        chk("t6_drained", q.size(), 0);
        chk("t6_rx_words", rx - rx0, 3 * DEPTH);
        tick();
        tick();
        chk("t6_req_idle", req, 0);
        gnt = 1'b0;

        // ---------------- asynchronous reset mid-burst ----------------
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(8'h60 + i);
            tick();
        end
        wr_en = 1'b0;
        gnt   = 1'b1;
        tick();
        tick();
        chk("t1_req_xfer", req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_req_async",   req,       0);
        chk("t1_bv_async",    bus_valid, 0);
        chk("t1_count_async", count,     0);
        chk("t1_empty_async", empty,     1);
        q.delete();
        gnt = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        tick();
        chk("t1_req_after",   req,       0);
        chk("t1_empty_after", empty,     1);
        chk("t1_bv_after",    bus_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Upstream client front-end for the two-requester arbiter: one instance per arbiter port.
- Buffers words written by a producer in a small FIFO and raises req whenever it holds data.
- While the arbiter grants, drains one word per cycle onto a shared bus.
- Enforces a maximum burst per grant, then yields req for one cycle to keep arbitration fair.

Parameters:
DATA_W, 8, width of buffered words and bus_data
DEPTH, 4, FIFO entries; power of two, >= 2
MAX_BURST, 4, maximum pops per continuous grant before forced yield; >= 1

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  producer write strobe
wr_data  input  DATA_W  producer write data
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
count  output  log2(DEPTH)+1  current occupancy
req  output  1  request to arbiter (req_0/req_1 of the arbiter)
gnt  input  1  grant from arbiter (gnt_0/gnt_1)
bus_data  output  DATA_W  word transferred on shared bus
bus_valid  output  1  bus_data valid this cycle

Behaviour:
- Reset (async, immediate):
  - FIFO emptied: count=0, empty=1, full=0.
  - State IDLE; req=0, bus_valid=0, bus_data=0; burst counter 0.
  - Reset mid-burst drops req and bus_valid at once; buffered words are discarded.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Write accepted at an edge iff wr_en=1 and full=0, using the registered full value from before that edge.
  - A write while full is dropped silently, even if a pop occurs in the same cycle.
  - full, empty and count are decoded from registered occupancy.
- pop = req & gnt & !empty, sampled at the rising edge.
  - Removes the head word.
  - bus_data <= head and bus_valid <= 1 at that edge; otherwise bus_valid <= 0 and bus_data holds its value.
  - One-cycle latency from sampled grant to bus_valid.
- Simultaneous write and pop: count unchanged, both take effect; FIFO order preserved.
- req = (state==REQ) | (state==XFER); registered, glitch-free.
- State machine, evaluated at each rising edge with pre-edge values:
  - IDLE: if !empty -> REQ; else stay. req rises the cycle after the first accepted write.
  - REQ:
    - gnt=1: pop; burst counter <= 1.
    - If MAX_BURST=1 -> YIELD.
    - Else if that pop empties the FIFO (count==1 and no accepted write) -> IDLE.
    - Otherwise -> XFER.
    - gnt=0: stay.
  - XFER:
    - gnt=0 (grant revoked): no pop; burst counter <= 0; -> REQ.
    - gnt=1: pop; burst counter += 1.
    - If the counter reaches MAX_BURST -> YIELD.
    - Else if the FIFO becomes empty -> IDLE.
    - Else stay.
  - YIELD: req=0 for exactly one cycle; burst counter <= 0; -> REQ if !empty, else IDLE.
- Priority when a pop both empties the FIFO and completes MAX_BURST: go to YIELD. YIELD still exits to IDLE when empty.
- A gnt seen while req=0 (IDLE/YIELD) is ignored: no pop, no state change.
- An empty FIFO never produces bus_valid.

Test Plan:
1. Reset mid-burst: assert reset asynchronously between edges during XFER -> req, bus_valid, count drop to 0 the same instant; after release, state IDLE and empty=1.
2. Single word: write 0x5A, gnt tied to req delayed one cycle (arbiter-like) -> req high 1 cycle after write; bus_valid=1 with bus_data=0x5A one cycle after gnt sampled; req=0, empty=1 afterwards.
3. Burst and yield: MAX_BURST=4, write 6 words 0x01..0x06, gnt held 1 -> bus 0x01..0x04 on consecutive cycles, req low exactly one cycle, then 0x05, 0x06, then IDLE.
4. Full / overflow: write 5 words with DEPTH=4, gnt=0 -> full=1 after 4, 5th dropped, count=4; later drain yields only the first 4 words in order.
5. Grant revocation: deassert gnt after 2 pops of a 4-word queue -> state REQ, req stays 1, no bus_valid; on re-grant the remaining 2 words follow in order with a fresh burst count.
6. Wrap and concurrent write/pop: continuous writes during a grant for 3*DEPTH words -> count stable, pointers wrap, output sequence equals input sequence with no loss or duplication.
